// File: rtl/params_noc.sv
// Shared NoC router parameters: port/VC counts, derived widths and the port-name enum.
package params_noc;

  localparam int unsigned PORT_NUM = 5;
  localparam int unsigned VC_NUM   = 2;
  localparam int unsigned VC_Size  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned REQ_NUM  = PORT_NUM * VC_NUM;
  localparam int unsigned PTR_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } inout_Port;

endpackage

// File: rtl/vc_allocator_if.sv
// Request/grant bundle between the per-input-VC status buffers and the VC allocator.
interface vc_allocator_if;
  import params_noc::*;

  logic [REQ_NUM-1:0]          vc_Req_i;
  inout_Port                   port_Req_i [REQ_NUM];
  logic [PORT_NUM*VC_NUM-1:0]  vc_Release_i;
  logic [REQ_NUM-1:0]          vc_Val_o;
  logic [VC_Size-1:0]          vc_New_o [REQ_NUM];
  logic [PORT_NUM*VC_NUM-1:0]  vc_Free_o;
  logic                        err_o;

  // Requester side (status buffers / downstream release feedback).
  modport master (
    output vc_Req_i, port_Req_i, vc_Release_i,
    input  vc_Val_o, vc_New_o, vc_Free_o, err_o
  );

  // Allocator side.
  modport slave (
    input  vc_Req_i, port_Req_i, vc_Release_i,
    output vc_Val_o, vc_New_o, vc_Free_o, err_o
  );

endinterface

// File: rtl/vc_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  input  logic            enable,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx,
  output logic            any_gnt
);

  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (enable && !any_gnt && req[idx]) begin
        any_gnt   = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/vc_allocator.sv
// Router VC allocator: per-output-port round-robin over requesters, lowest free downstream VC.
module vc_allocator
  import params_noc::*;
(
  input logic             clk,
  input logic             rst_n,
  vc_allocator_if.slave   bus
);

  logic [REQ_NUM-1:0]         eff, port_ok;
  logic [REQ_NUM-1:0]         cand    [PORT_NUM];
  logic [REQ_NUM-1:0]         gnt     [PORT_NUM];
  logic [PTR_W-1:0]           gnt_idx [PORT_NUM];
  logic [PORT_NUM-1:0]        any_gnt, vc_avail;
  logic [VC_Size-1:0]         vsel    [PORT_NUM];
  logic                       err_port;

  logic [PTR_W-1:0]           ptr_q [PORT_NUM], ptr_d [PORT_NUM];
  logic [PORT_NUM*VC_NUM-1:0] free_q, free_d;
  logic [REQ_NUM-1:0]         val_q, val_d;
  logic [VC_Size-1:0]         new_q [REQ_NUM], new_d [REQ_NUM];
  logic                       err_q, err_d;

  // A requester being presented a grant this cycle still holds vc_Req; mask it.
  always_comb begin
    err_port = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      eff[i]     = bus.vc_Req_i[i] & ~val_q[i];
      port_ok[i] = 32'(bus.port_Req_i[i]) < PORT_NUM;
      if (eff[i] && !port_ok[i]) err_port = 1'b1;
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        cand[p][i] = eff[i] & port_ok[i] & (32'(bus.port_Req_i[i]) == p);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      vsel[p]     = '0;
      vc_avail[p] = 1'b0;
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        if (free_q[p*VC_NUM+v]) begin
          vsel[p]     = VC_Size'(v);
          vc_avail[p] = 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_arb
    rr_arbiter #(.N(REQ_NUM)) u_arb (
      .req     (cand[p]),
      .ptr     (ptr_q[p]),
      .enable  (vc_avail[p]),
      .gnt     (gnt[p]),
      .gnt_idx (gnt_idx[p]),
      .any_gnt (any_gnt[p])
    );
  end

  always_comb begin
    free_d = free_q;
    val_d  = '0;
    ptr_d  = ptr_q;
    err_d  = err_port;
    for (int i = 0; i < REQ_NUM; i++) new_d[i] = '0;
    // Releasing an already-free VC is a protocol error and changes nothing.
    for (int k = 0; k < PORT_NUM*VC_NUM; k++) begin
      if (bus.vc_Release_i[k]) begin
        if (free_q[k]) err_d = 1'b1;
        else           free_d[k] = 1'b1;
      end
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      if (any_gnt[p]) begin
        free_d[p*VC_NUM+32'(vsel[p])] = 1'b0;
        val_d              = val_d | gnt[p];
        new_d[gnt_idx[p]]  = vsel[p];
        ptr_d[p] = (32'(gnt_idx[p]) == REQ_NUM - 1) ? '0 : gnt_idx[p] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q <= '1;
      val_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < REQ_NUM; i++)  new_q[i] <= '0;
      for (int p = 0; p < PORT_NUM; p++) ptr_q[p] <= '0;
    end else begin
      free_q <= free_d;
      val_q  <= val_d;
      err_q  <= err_d;
      new_q  <= new_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus.vc_Val_o  = val_q;
  assign bus.vc_New_o  = new_q;
  assign bus.vc_Free_o = free_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Directed self-checking bench for vc_allocator with hand-computed expectations.
module tb_vc_allocator;
  import params_noc::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  vc_allocator_if bus ();

  vc_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.vc_Req_i     = '0;
    bus.vc_Release_i = '0;
    for (int i = 0; i < REQ_NUM; i++) bus.port_Req_i[i] = LOCAL;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    check("rst_free", 32'(bus.vc_Free_o), 32'h3FF);
    check("rst_val", 32'(bus.vc_Val_o), 32'h0);
    check("rst_err", 32'(bus.err_o), 32'h0);
    check("rst_new0", 32'(bus.vc_New_o[0]), 32'h0);

    // Single request held two cycles
    bus.vc_Req_i[0] = 1'b1;
    bus.port_Req_i[0] = EAST;
    tick();
    check("single_val", 32'(bus.vc_Val_o), 32'h001);
    check("single_new", 32'(bus.vc_New_o[0]), 32'h0);
    check("single_free", 32'(bus.vc_Free_o), 32'h3BF);
    tick();
    bus.vc_Req_i[0] = 1'b0;
    check("single_nodup", 32'(bus.vc_Val_o), 32'h000);
    check("single_free2", 32'(bus.vc_Free_o), 32'h3BF);
    tick();
    check("single_quiet", 32'(bus.vc_Val_o), 32'h000);

    // Contention on NORTH: 2, 5, 7
    do_reset();
    bus.vc_Req_i[2] = 1'b1; bus.port_Req_i[2] = NORTH;
    bus.vc_Req_i[5] = 1'b1; bus.port_Req_i[5] = NORTH;
    bus.vc_Req_i[7] = 1'b1; bus.port_Req_i[7] = NORTH;
    tick();
    check("cont_g2_val", 32'(bus.vc_Val_o), 32'h004);
    check("cont_g2_new", 32'(bus.vc_New_o[2]), 32'h0);
    check("cont_g2_free", 32'(bus.vc_Free_o), 32'h3FB);
    bus.vc_Req_i[2] = 1'b0;
    tick();
    check("cont_g5_val", 32'(bus.vc_Val_o), 32'h020);
    check("cont_g5_new", 32'(bus.vc_New_o[5]), 32'h1);
    check("cont_g5_free", 32'(bus.vc_Free_o), 32'h3F3);
    bus.vc_Req_i[5] = 1'b0;
    tick();
    check("cont_7wait", 32'(bus.vc_Val_o), 32'h000);
    bus.vc_Release_i[NORTH*VC_NUM+0] = 1'b1;
    tick();
    bus.vc_Release_i = '0;
    check("cont_rel_free", 32'(bus.vc_Free_o), 32'h3F7);
    check("cont_rel_nogr", 32'(bus.vc_Val_o), 32'h000);
    check("cont_rel_err", 32'(bus.err_o), 32'h0);
    tick();
    check("cont_g7_val", 32'(bus.vc_Val_o), 32'h080);
    check("cont_g7_new", 32'(bus.vc_New_o[7]), 32'h0);
    check("cont_g7_free", 32'(bus.vc_Free_o), 32'h3F3);
    bus.vc_Req_i[7] = 1'b0;

    // Parallel ports
    do_reset();
    bus.vc_Req_i[0] = 1'b1; bus.port_Req_i[0] = LOCAL;
    bus.vc_Req_i[3] = 1'b1; bus.port_Req_i[3] = WEST;
    tick();
    bus.vc_Req_i = '0;
    check("par_val", 32'(bus.vc_Val_o), 32'h009);
    check("par_new0", 32'(bus.vc_New_o[0]), 32'h0);
    check("par_new3", 32'(bus.vc_New_o[3]), 32'h0);
    check("par_free", 32'(bus.vc_Free_o), 32'h2FE);

    // Pointer wrap on SOUTH: grant 8 first so ptr becomes 9
    do_reset();
    bus.vc_Req_i[8] = 1'b1; bus.port_Req_i[8] = SOUTH;
    tick();
    check("wrap_g8", 32'(bus.vc_Val_o), 32'h100);
    check("wrap_free8", 32'(bus.vc_Free_o), 32'h3EF);
    bus.vc_Req_i[8] = 1'b0;
    bus.vc_Release_i[SOUTH*VC_NUM+0] = 1'b1;
    tick();
    bus.vc_Release_i = '0;
    check("wrap_freed", 32'(bus.vc_Free_o), 32'h3FF);
    bus.vc_Req_i[9] = 1'b1; bus.port_Req_i[9] = SOUTH;
    bus.vc_Req_i[1] = 1'b1; bus.port_Req_i[1] = SOUTH;
    tick();
    check("wrap_g9_val", 32'(bus.vc_Val_o), 32'h200);
    check("wrap_g9_new", 32'(bus.vc_New_o[9]), 32'h0);
    bus.vc_Req_i[9] = 1'b0;
    tick();
    check("wrap_g1_val", 32'(bus.vc_Val_o), 32'h002);
    check("wrap_g1_new", 32'(bus.vc_New_o[1]), 32'h1);
    check("wrap_free", 32'(bus.vc_Free_o), 32'h3CF);
    bus.vc_Req_i[1] = 1'b0;

    // Errors
    do_reset();
    bus.vc_Release_i[0] = 1'b1;
    tick();
    bus.vc_Release_i = '0;
    check("err_rel", 32'(bus.err_o), 32'h1);
    check("err_rel_free", 32'(bus.vc_Free_o), 32'h3FF);
    check("err_rel_val", 32'(bus.vc_Val_o), 32'h000);
    tick();
    check("err_rel_pulse", 32'(bus.err_o), 32'h0);
    bus.vc_Req_i[4] = 1'b1;
    bus.port_Req_i[4] = inout_Port'(3'd6);
    tick();
    bus.vc_Req_i[4] = 1'b0;
    bus.port_Req_i[4] = LOCAL;
    check("err_port", 32'(bus.err_o), 32'h1);
    check("err_port_val", 32'(bus.vc_Val_o), 32'h000);
    check("err_port_free", 32'(bus.vc_Free_o), 32'h3FF);
    tick();
    check("err_port_pulse", 32'(bus.err_o), 32'h0);

    // Reset mid-operation with EAST fully busy
    do_reset();
    bus.vc_Req_i[0] = 1'b1; bus.port_Req_i[0] = EAST;
    bus.vc_Req_i[1] = 1'b1; bus.port_Req_i[1] = EAST;
    tick();
    bus.vc_Req_i[0] = 1'b0;
    tick();
    bus.vc_Req_i[1] = 1'b0;
    check("rmid_val1", 32'(bus.vc_Val_o), 32'h002);
    check("rmid_busy", 32'(bus.vc_Free_o), 32'h33F);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_free", 32'(bus.vc_Free_o), 32'h3FF);
    check("rmid_val", 32'(bus.vc_Val_o), 32'h000);
    tick();
    rst_n = 1'b1;
    bus.vc_Req_i[2] = 1'b1; bus.port_Req_i[2] = EAST;
    tick();
    bus.vc_Req_i[2] = 1'b0;
    check("rmid_post_val", 32'(bus.vc_Val_o), 32'h004);
    check("rmid_post_new", 32'(bus.vc_New_o[2]), 32'h0);
    check("rmid_post_free", 32'(bus.vc_Free_o), 32'h3BF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
